uart_tx_serializer: RTL and testbench

- Transmit serializer that sits directly downstream of the 256x8 TX FIFO in the CoreUARTapb datapath.
- Pops one byte at a time through the FIFO's active-low read strobe and serialises it onto the TX line: start bit, 7 or 8 data bits LSB first, optional parity, one stop bit.
- Bit timing comes from an external x16 baud-rate enable.
- Single clock domain; the FIFO read clock is the same CLK.

---
 rtl/uart_tx_serializer.sv | 203 ++++++++++++++++++++
 tb/tb_uart_tx_serializer.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_serializer.sv
// UART transmit serializer: pops bytes from the TX FIFO and sends start, 7/8 data bits LSB first,
// optional parity and one stop bit, paced by a x16 baud enable. Parity exists only with UART_TX_PARITY_EN.
module uart_tx_serializer #(
  parameter int unsigned FIFO_RD_LAT = 2
) (
  input  logic       CLK,
  input  logic       RESET_N,
  input  logic       baud_en,
  input  logic       bit8,
`ifdef UART_TX_PARITY_EN
  input  logic       parity_en,
  input  logic       odd_n_even,
`endif
  input  logic       fifo_empty,
  input  logic [7:0] fifo_data,
  output logic       fifo_rd_n,
  output logic       tx,
  output logic       tx_busy,
  output logic       tx_done
);

  localparam int unsigned DATA_W = 8;
  localparam int unsigned TICK_W = 4;
  localparam int unsigned IDX_W  = 3;
  localparam int unsigned LAT_W  = 2;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    START  = 3'd2,
    DATA   = 3'd3,
`ifdef UART_TX_PARITY_EN
    PARITY = 3'd4,
`endif
    STOP   = 3'd5
  } state_t;

  state_t              state_q, state_d;
  logic [TICK_W-1:0]   tick_q, tick_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [LAT_W-1:0]    lat_q, lat_d;
  logic [DATA_W-1:0]   sh_q, sh_d;
  logic                par_q, par_d;
  logic                bit8_q, bit8_d;
  logic                tx_q, tx_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
`ifdef UART_TX_PARITY_EN
  logic                par_en_q, par_en_d;
  logic                odd_q, odd_d;
`endif
  logic                strobe_c;
  logic                bit_end_c;
  logic [IDX_W-1:0]    last_c;

  // State and datapath registers
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q  <= IDLE;
      tick_q   <= '0;
      idx_q    <= '0;
      lat_q    <= '0;
      sh_q     <= '0;
      par_q    <= 1'b0;
      bit8_q   <= 1'b0;
      tx_q     <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_en_q <= 1'b0;
      odd_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      tick_q   <= tick_d;
      idx_q    <= idx_d;
      lat_q    <= lat_d;
      sh_q     <= sh_d;
      par_q    <= par_d;
      bit8_q   <= bit8_d;
      tx_q     <= tx_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
`ifdef UART_TX_PARITY_EN
      par_en_q <= par_en_d;
      odd_q    <= odd_d;
`endif
    end
  end

  // Next-state, bit timing and serial data
  always_comb begin
    state_d   = state_q;
    tick_d    = tick_q;
    idx_d     = idx_q;
    lat_d     = lat_q;
    sh_d      = sh_q;
    par_d     = par_q;
    bit8_d    = bit8_q;
    tx_d      = tx_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    strobe_c  = 1'b0;
`ifdef UART_TX_PARITY_EN
    par_en_d  = par_en_q;
    odd_d     = odd_q;
`endif
    bit_end_c = baud_en && (&tick_q);
    last_c    = bit8_q ? IDX_W'(7) : IDX_W'(6);

    if (baud_en) begin
      tick_d = tick_q + TICK_W'(1);
    end

    case (state_q)
      IDLE: begin
        tx_d   = 1'b1;
        tick_d = '0;
        if (!fifo_empty) begin
          strobe_c = 1'b1;
          busy_d   = 1'b1;
          lat_d    = '0;
          state_d  = FETCH;
        end
      end
      FETCH: begin
        tx_d   = 1'b1;
        tick_d = '0;
        if (lat_q == LAT_W'(FIFO_RD_LAT - 1)) begin
          sh_d    = fifo_data;
          idx_d   = '0;
          par_d   = 1'b0;
          tx_d    = 1'b0;
          state_d = START;
        end else begin
          lat_d = lat_q + LAT_W'(1);
        end
      end
      START: begin
        // Frame format is latched here so mid-frame control changes cannot corrupt it
        if (bit_end_c) begin
          bit8_d   = bit8;
`ifdef UART_TX_PARITY_EN
          par_en_d = parity_en;
          odd_d    = odd_n_even;
`endif
          tx_d     = sh_q[0];
          par_d    = par_q ^ sh_q[0];
          sh_d     = sh_q >> 1;
          idx_d    = '0;
          state_d  = DATA;
        end
      end
      DATA: begin
        if (bit_end_c) begin
          if (idx_q == last_c) begin
            state_d = STOP;
            tx_d    = 1'b1;
`ifdef UART_TX_PARITY_EN
            if (par_en_q) begin
              state_d = PARITY;
              tx_d    = par_q ^ odd_q;
            end
`endif
          end else begin
            tx_d  = sh_q[0];
            par_d = par_q ^ sh_q[0];
            sh_d  = sh_q >> 1;
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (bit_end_c) begin
          tx_d    = 1'b1;
          state_d = STOP;
        end
      end
`endif
      STOP: begin
        if (bit_end_c) begin
          tx_d    = 1'b1;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: begin
        tx_d    = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // Strobe is issued in the IDLE cycle itself and held off while reset is asserted
  assign fifo_rd_n = ~(strobe_c & RESET_N);
  assign tx        = tx_q;
  assign tx_busy   = busy_q;
  assign tx_done   = done_q;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Randomized bench for uart_tx_serializer: FIFO model with read latency plus a frame-timeline reference.
// Builds with or without UART_TX_PARITY_EN.
module tb_uart_tx_serializer;

  localparam int unsigned LAT      = 2;
  localparam int          MAX_WAIT = 4000;

  logic       CLK        = 1'b0;
  logic       RESET_N    = 1'b0;
  logic       baud_en    = 1'b0;
  logic       bit8       = 1'b1;
`ifdef UART_TX_PARITY_EN
  logic       parity_en  = 1'b0;
  logic       odd_n_even = 1'b0;
`endif
  logic       fifo_empty = 1'b1;
  logic [7:0] fifo_data;
  logic       fifo_rd_n;
  logic       tx;
  logic       tx_busy;
  logic       tx_done;

  int total = 0;
  int bad   = 0;

  uart_tx_serializer #(.FIFO_RD_LAT(LAT)) dut (
    .CLK        (CLK),
    .RESET_N    (RESET_N),
    .baud_en    (baud_en),
    .bit8       (bit8),
`ifdef UART_TX_PARITY_EN
    .parity_en  (parity_en),
    .odd_n_even (odd_n_even),
`endif
    .fifo_empty (fifo_empty),
    .fifo_data  (fifo_data),
    .fifo_rd_n  (fifo_rd_n),
    .tx         (tx),
    .tx_busy    (tx_busy),
    .tx_done    (tx_done)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // FIFO model: data is valid LAT cycles after the strobe cycle, garbage otherwise
  logic [7:0] fq[$];
  logic [7:0] pipe [0:2];
  logic [7:0] fifo_v;
  int         rd_cnt   = 0;
  int         done_cnt = 0;

  assign fifo_data = pipe[LAT-1];

  always @(posedge CLK) begin
    fifo_v = 8'($urandom);
    if (!fifo_rd_n) begin
      rd_cnt++;
      if (fq.size() > 0) fifo_v = fq.pop_front();
    end
    if (tx_done) done_cnt++;
    pipe[0]    <= fifo_v;
    pipe[1]    <= pipe[0];
    pipe[2]    <= pipe[1];
    fifo_empty <= (fq.size() == 0);
  end

  // Reference timeline: strobe, LAT fetch cycles, then each frame bit lasts 16 baud pulses
  logic [7:0] exp_q[$];
  logic       bits [0:10];
  int         ph        = 0;
  int         fetch_left = 0;
  int         pulses    = 0;
  int         nbits     = 0;
  logic       done_pend = 1'b0;
  logic       prev_rd   = 1'b1;
  logic       e_tx, e_busy, e_rd;
  logic [7:0] m_byte;
  int         nd;

  always @(negedge CLK) begin
    if (!RESET_N) begin
      ph        = 0;
      done_pend = 1'b0;
      prev_rd   = 1'b1;
    end else begin
      e_tx   = 1'b1;
      e_busy = (ph != 0);
      e_rd   = 1'b1;
      if (ph == 2) e_tx = bits[pulses / 16];
      if (ph == 0) e_rd = fifo_empty;
      check("tx",        32'(tx),        32'(e_tx));
      check("tx_busy",   32'(tx_busy),   32'(e_busy));
      check("tx_done",   32'(tx_done),   32'(done_pend));
      check("fifo_rd_n", 32'(fifo_rd_n), 32'(e_rd));
      check("rd_single", 32'(prev_rd | fifo_rd_n), 32'(1));
      prev_rd   = fifo_rd_n;
      done_pend = 1'b0;
      case (ph)
        0: if (!fifo_empty) begin
          m_byte = (exp_q.size() > 0) ? exp_q.pop_front() : 8'h00;
          nd     = bit8 ? 8 : 7;
          bits[0] = 1'b0;
          for (int i = 0; i < nd; i++) bits[i+1] = m_byte[i];
          nbits = nd + 1;
`ifdef UART_TX_PARITY_EN
          if (parity_en) begin
            bits[nbits] = (^(m_byte & (bit8 ? 8'hFF : 8'h7F))) ^ odd_n_even;
            nbits++;
          end
`endif
          bits[nbits] = 1'b1;
          nbits++;
          ph         = 1;
          fetch_left = LAT;
        end
        1: begin
          fetch_left--;
          if (fetch_left == 0) begin
            ph     = 2;
            pulses = 0;
          end
        end
        default: begin
          if (baud_en) pulses++;
          if (pulses == 16 * nbits) begin
            ph        = 0;
            done_pend = 1'b1;
          end
        end
      endcase
    end
  end

  int baud_pct = 100;
  int pushed   = 0;
  int r0;
  int d0;
  int n;

  task automatic tick();
    @(posedge CLK);
    #1;
    baud_en = ($urandom_range(99) < baud_pct);
  endtask

  task automatic push(input logic [7:0] b);
    fq.push_back(b);
    exp_q.push_back(b);
    pushed++;
  endtask

  task automatic wait_idle(input int budget);
    int k;
    k = 0;
    while (!(ph == 0 && exp_q.size() == 0 && fifo_empty && !done_pend) && k < budget) begin
      tick();
      k++;
    end
    check("idle_timeout", 32'(k < budget), 32'(1));
  endtask

  initial begin
    // Reset holds strobe off even with a byte waiting
    repeat (2) tick();
    push(8'h55);
    repeat (3) tick();
    check("rst_tx",      32'(tx),        32'(1));
    check("rst_rd_n",    32'(fifo_rd_n), 32'(1));
    check("rst_busy",    32'(tx_busy),   32'(0));
    check("rst_done",    32'(tx_done),   32'(0));
    RESET_N = 1'b1;
    wait_idle(MAX_WAIT);
    check("strobes_55", 32'(rd_cnt),   32'(1));
    check("dones_55",   32'(done_cnt), 32'(1));

    bit8 = 1'b0;
    push(8'hFF);
    wait_idle(MAX_WAIT);
    check("dones_ff7", 32'(done_cnt), 32'(2));

`ifdef UART_TX_PARITY_EN
    bit8       = 1'b1;
    parity_en  = 1'b1;
    odd_n_even = 1'b0;
    push(8'h07);
    wait_idle(MAX_WAIT);
    odd_n_even = 1'b1;
    push(8'h07);
    wait_idle(MAX_WAIT);
    parity_en  = 1'b0;
`endif

    bit8 = 1'b1;
    r0 = rd_cnt;
    d0 = done_cnt;
    push(8'hA5);
    push(8'h3C);
    wait_idle(MAX_WAIT);
    check("b2b_strobes", 32'(rd_cnt - r0),   32'(2));
    check("b2b_dones",   32'(done_cnt - d0), 32'(2));

    baud_pct = 50;
    r0 = rd_cnt;
    repeat (1000) tick();
    check("empty_strobes", 32'(rd_cnt - r0), 32'(0));

    for (int b = 0; b < 8; b++) begin
      baud_pct = $urandom_range(100, 20);
      bit8     = 1'($urandom_range(1));
`ifdef UART_TX_PARITY_EN
      parity_en  = 1'($urandom_range(1));
      odd_n_even = 1'($urandom_range(1));
`endif
      nd = $urandom_range(3, 1);
      for (int j = 0; j < nd; j++) push(8'($urandom));
      wait_idle(MAX_WAIT);
    end

    // Asynchronous reset during data bit 3 abandons the frame
    baud_pct = 100;
    bit8     = 1'b1;
    push(8'h5A);
    n = 0;
    while (!(ph == 2 && pulses / 16 == 4) && n < MAX_WAIT) begin
      tick();
      n++;
    end
    check("reach_bit3", 32'(n < MAX_WAIT), 32'(1));
    #2;
    RESET_N = 1'b0;
    #1;
    check("arst_tx",   32'(tx),        32'(1));
    check("arst_busy", 32'(tx_busy),   32'(0));
    check("arst_rd_n", 32'(fifo_rd_n), 32'(1));
    repeat (2) tick();
    RESET_N = 1'b1;
    r0 = rd_cnt;
    repeat (50) tick();
    check("post_rst_strobes", 32'(rd_cnt - r0), 32'(0));

    check("strobes_total", 32'(rd_cnt),   32'(pushed));
    check("dones_total",   32'(done_cnt), 32'(pushed - 1));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
